// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register with redirect/predict/stall/wait handling,
// the IF/ID pipeline register, and a saturating count of pipeline flushes.
module pc_fetch_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_pc_sel,
  input  logic        i_flush,
  input  logic [31:0] i_alu_ex,
  input  logic [31:0] i_pc_four_EX,
  input  logic [31:0] i_pred_pc,
  input  logic        i_stall,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc_now,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_pc_ID,
  output logic [31:0] o_pc_four_ID,
  output logic [31:0] o_instr_ID,
  output logic        o_valid_ID,
  output logic        o_pred_taken_ID,
  output logic [15:0] o_flush_cnt
);

  localparam logic [1:0]  SEL_SEQ    = 2'b00;
  localparam logic [1:0]  SEL_EX_TGT = 2'b01;
  localparam logic [1:0]  SEL_EX_FT  = 2'b10;
  localparam logic [1:0]  SEL_PRED   = 2'b11;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic [31:0] r_pc;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc_four_id;
  logic [31:0] r_instr_id;
  logic        r_valid_id;
  logic        r_pred_taken_id;
  logic [15:0] r_flush_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_raw;
  logic [31:0] w_next_pc;
  logic        w_redirect;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_next_raw = w_pc_plus4;
    case (i_pc_sel)
      SEL_SEQ:    w_next_raw = w_pc_plus4;
      SEL_EX_TGT: w_next_raw = i_alu_ex;
      SEL_EX_FT:  w_next_raw = i_pc_four_EX;
      SEL_PRED:   w_next_raw = i_pred_pc;
      default:    w_next_raw = w_pc_plus4;
    endcase
  end

  // Fetch addresses are always word aligned, whatever the source supplies.
  assign w_next_pc  = w_next_raw & ~32'h3;
  assign w_redirect = i_flush && ((i_pc_sel == SEL_EX_TGT) || (i_pc_sel == SEL_EX_FT));

  // A resolved mispredict must win even over a stall or a pending memory wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= 32'h0;
    end else if (w_redirect) begin
      r_pc <= w_next_pc;
    end else if (!i_stall && i_imem_ready) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_id         <= 32'h0;
      r_pc_four_id    <= 32'h0;
      r_instr_id      <= NOP_INSTR;
      r_valid_id      <= 1'b0;
      r_pred_taken_id <= 1'b0;
    end else if (i_flush || (!i_stall && !i_imem_ready)) begin
      r_pc_id         <= 32'h0;
      r_pc_four_id    <= 32'h0;
      r_instr_id      <= NOP_INSTR;
      r_valid_id      <= 1'b0;
      r_pred_taken_id <= 1'b0;
    end else if (!i_stall) begin
      r_pc_id         <= r_pc;
      r_pc_four_id    <= w_pc_plus4;
      r_instr_id      <= i_imem_rdata;
      r_valid_id      <= 1'b1;
      r_pred_taken_id <= (i_pc_sel == SEL_PRED);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush_cnt <= 16'h0;
    end else if (i_flush && (r_flush_cnt != 16'hFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign o_pc_now        = r_pc;
  assign o_imem_addr     = r_pc;
  assign o_pc_ID         = r_pc_id;
  assign o_pc_four_ID    = r_pc_four_id;
  assign o_instr_ID      = r_instr_id;
  assign o_valid_ID      = r_valid_id;
  assign o_pred_taken_ID = r_pred_taken_id;
  assign o_flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: directed vectors push hand-computed
// post-edge snapshots into a queue that an independent monitor drains.
module tb_pc_fetch_stage;

  typedef struct packed {
    logic [31:0] pcNow;
    logic [31:0] pcId;
    logic [31:0] pcFourId;
    logic [31:0] instrId;
    logic        validId;
    logic        predId;
    logic [15:0] flushCnt;
  } expT;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstN;
  logic [1:0]  pcSel;
  logic        flush;
  logic [31:0] aluEx;
  logic [31:0] pcFourEx;
  logic [31:0] predPc;
  logic        stall;
  logic [31:0] imemRdata;
  logic        imemReady;
  logic [31:0] pcNow;
  logic [31:0] imemAddr;
  logic [31:0] pcId;
  logic [31:0] pcFourId;
  logic [31:0] instrId;
  logic        validId;
  logic        predTakenId;
  logic [15:0] flushCnt;

  int checks = 0;
  int fails  = 0;
  expT   expQ[$];
  string nameQ[$];

  pc_fetch_stage dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_pc_sel(pcSel),
    .i_flush(flush),
    .i_alu_ex(aluEx),
    .i_pc_four_EX(pcFourEx),
    .i_pred_pc(predPc),
    .i_stall(stall),
    .i_imem_rdata(imemRdata),
    .i_imem_ready(imemReady),
    .o_pc_now(pcNow),
    .o_imem_addr(imemAddr),
    .o_pc_ID(pcId),
    .o_pc_four_ID(pcFourId),
    .o_instr_ID(instrId),
    .o_valid_ID(validId),
    .o_pred_taken_ID(predTakenId),
    .o_flush_cnt(flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic expT mkExp(input logic [31:0] pc, input logic [31:0] pid,
                                input logic [31:0] p4, input logic [31:0] ins,
                                input logic v, input logic pr, input logic [15:0] cnt);
    expT e;
    e.pcNow = pc; e.pcId = pid; e.pcFourId = p4; e.instrId = ins;
    e.validId = v; e.predId = pr; e.flushCnt = cnt;
    return e;
  endfunction

  task automatic checkOutput(input string name, input expT e);
    expT a;
    a = mkExp(pcNow, pcId, pcFourId, instrId, validId, predTakenId, flushCnt);
    checks++;
    if (a !== e || imemAddr !== e.pcNow) begin
      fails++;
      $display("[TB] FAIL %s: got pc=%h addr=%h pcID=%h pc4ID=%h instr=%h v=%b pt=%b cnt=%h, want pc=%h pcID=%h pc4ID=%h instr=%h v=%b pt=%b cnt=%h",
               name, a.pcNow, imemAddr, a.pcId, a.pcFourId, a.instrId, a.validId, a.predId, a.flushCnt,
               e.pcNow, e.pcId, e.pcFourId, e.instrId, e.validId, e.predId, e.flushCnt);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] sel, input logic fl,
                               input logic st, input logic rdy, input logic [31:0] alu,
                               input logic [31:0] p4ex, input logic [31:0] pred,
                               input logic [31:0] rdata, input expT e);
    @(negedge clk);
    pcSel = sel; flush = fl; stall = st; imemReady = rdy;
    aluEx = alu; pcFourEx = p4ex; predPc = pred; imemRdata = rdata;
    @(posedge clk);
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: compares every snapshot the stimulus expects, just after the edge.
  initial begin
    expT   e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b1; pcSel = 2'b00; flush = 1'b0; stall = 1'b0; imemReady = 1'b1;
    aluEx = '0; pcFourEx = '0; predPc = '0; imemRdata = '0;
    #2 rstN = 1'b0;
    #2 checkOutput("reset_async", mkExp(0, 0, 0, NOP, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #2 rstN = 1'b1;

    applyStimulus("seq1", 2'b00, 0, 0, 1, 0, 0, 0, 32'h1111_0000, mkExp(32'h4, 32'h0, 32'h4, 32'h1111_0000, 1, 0, 0));
    applyStimulus("seq2", 2'b00, 0, 0, 1, 0, 0, 0, 32'h1111_0004, mkExp(32'h8, 32'h4, 32'h8, 32'h1111_0004, 1, 0, 0));
    applyStimulus("seq3", 2'b00, 0, 0, 1, 0, 0, 0, 32'h1111_0008, mkExp(32'hC, 32'h8, 32'hC, 32'h1111_0008, 1, 0, 0));
    applyStimulus("seq4", 2'b00, 0, 0, 1, 0, 0, 0, 32'h1111_000C, mkExp(32'h10, 32'hC, 32'h10, 32'h1111_000C, 1, 0, 0));
    applyStimulus("pred_to_20", 2'b11, 0, 0, 1, 0, 0, 32'h20, 32'h2222_0010, mkExp(32'h20, 32'h10, 32'h14, 32'h2222_0010, 1, 1, 0));
    applyStimulus("mispredict", 2'b01, 1, 1, 1, 32'h100, 0, 0, 32'hDEAD_0020, mkExp(32'h100, 0, 0, NOP, 0, 0, 1));
    applyStimulus("after_redir", 2'b00, 0, 0, 1, 0, 0, 0, 32'h3333_0100, mkExp(32'h104, 32'h100, 32'h104, 32'h3333_0100, 1, 0, 1));
    applyStimulus("pred_to_40", 2'b11, 0, 0, 1, 0, 0, 32'h40, 32'h3333_0104, mkExp(32'h40, 32'h104, 32'h108, 32'h3333_0104, 1, 1, 1));
    applyStimulus("pred_taken", 2'b11, 0, 0, 1, 0, 0, 32'h80, 32'h4444_0040, mkExp(32'h80, 32'h40, 32'h44, 32'h4444_0040, 1, 1, 1));
    applyStimulus("stall1", 2'b11, 0, 1, 1, 0, 0, 32'h200, 32'hBAD0_0001, mkExp(32'h80, 32'h40, 32'h44, 32'h4444_0040, 1, 1, 1));
    applyStimulus("stall2", 2'b00, 0, 1, 1, 0, 0, 0, 32'hBAD0_0002, mkExp(32'h80, 32'h40, 32'h44, 32'h4444_0040, 1, 1, 1));
    applyStimulus("stall3", 2'b00, 0, 1, 0, 0, 0, 0, 32'hBAD0_0003, mkExp(32'h80, 32'h40, 32'h44, 32'h4444_0040, 1, 1, 1));
    applyStimulus("wait1", 2'b00, 0, 0, 0, 0, 0, 0, 32'hBAD0_0004, mkExp(32'h80, 0, 0, NOP, 0, 0, 1));
    applyStimulus("wait2", 2'b00, 0, 0, 0, 0, 0, 0, 32'hBAD0_0005, mkExp(32'h80, 0, 0, NOP, 0, 0, 1));
    applyStimulus("resume", 2'b00, 0, 0, 1, 0, 0, 0, 32'h5555_0080, mkExp(32'h84, 32'h80, 32'h84, 32'h5555_0080, 1, 0, 1));
    applyStimulus("flush_seq", 2'b00, 1, 0, 1, 32'h900, 0, 0, 32'hBAD0_0006, mkExp(32'h88, 0, 0, NOP, 0, 0, 2));
    applyStimulus("redir_ft_wait", 2'b10, 1, 0, 0, 0, 32'h300, 0, 32'hBAD0_0007, mkExp(32'h300, 0, 0, NOP, 0, 0, 3));
    applyStimulus("unaligned_tgt", 2'b01, 0, 0, 1, 32'h403, 0, 0, 32'h6666_0300, mkExp(32'h400, 32'h300, 32'h304, 32'h6666_0300, 1, 0, 3));
    applyStimulus("flush_pred_stall", 2'b11, 1, 1, 1, 0, 0, 32'h500, 32'hBAD0_0008, mkExp(32'h400, 0, 0, NOP, 0, 0, 4));
    applyStimulus("pred_to_top", 2'b11, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h7777_0400, mkExp(32'hFFFF_FFFC, 32'h400, 32'h404, 32'h7777_0400, 1, 1, 4));
    applyStimulus("wrap", 2'b00, 0, 0, 1, 0, 0, 0, 32'h8888_FFFC, mkExp(32'h0, 32'hFFFF_FFFC, 32'h0, 32'h8888_FFFC, 1, 0, 4));

    for (int k = 1; k <= 32'h10005; k++) begin
      applyStimulus("saturate", 2'b00, 1, 0, 1, 0, 0, 0, 32'hBAD0_0009,
                    mkExp(32'(4 * k), 0, 0, NOP, 0, 0, (k + 4 > 65535) ? 16'hFFFF : 16'(k + 4)));
    end

    #2;
    pcSel = 2'b01; flush = 1'b1; stall = 1'b1; aluEx = 32'h900;
    rstN = 1'b0;
    #1 checkOutput("reset_mid", mkExp(0, 0, 0, NOP, 0, 0, 0));
    @(posedge clk);
    #2 rstN = 1'b1;
    applyStimulus("post_reset1", 2'b00, 0, 0, 1, 0, 0, 0, 32'hABCD_0000, mkExp(32'h4, 32'h0, 32'h4, 32'hABCD_0000, 1, 0, 0));
    applyStimulus("post_reset2", 2'b00, 0, 0, 1, 0, 0, 0, 32'hABCD_0004, mkExp(32'h8, 32'h4, 32'h8, 32'hABCD_0004, 1, 0, 0));

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
- Clock: i_clk.
- Reset: i_rst_n.

REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- i_clk, in, 1: rising-edge clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_pc_sel, in, 2: next-PC select from the branch predictor/resolver.
  - 00 = sequential.
  - 01 = EX target.
  - 10 = EX fall-through.
  - 11 = BTB predicted target.
- i_flush, in, 1: EX-stage mispredict; asserted in the same cycle as i_pc_sel = 01 or 10.
- i_alu_ex, in, 32: resolved jump/branch target from EX.
- i_pc_four_EX, in, 32: EX PC+4 (not-taken recovery address).
- i_pred_pc, in, 32: BTB predicted target for the current PC.
- i_stall, in, 1: load-use hazard; freeze PC and IF/ID.
- i_imem_rdata, in, 32: instruction word for o_imem_addr.
- i_imem_ready, in, 1: i_imem_rdata valid this cycle.
- o_pc_now, out, 32: current fetch PC; also feeds the BTB lookup.
- o_imem_addr, out, 32: instruction memory address; equals o_pc_now.
- o_pc_ID, out, 32: IF/ID registered PC.
- o_pc_four_ID, out, 32: IF/ID registered PC+4.
- o_instr_ID, out, 32: IF/ID registered instruction.
- o_valid_ID, out, 1: IF/ID holds a real instruction.
- o_pred_taken_ID, out, 1: the instruction in ID was fetched with a taken prediction (i_pc_sel = 11).
- o_flush_cnt, out, 16: saturating count of accepted flushes.

Function
REQ-003 SHALL compute next_pc combinationally from i_pc_sel:
- 00: o_pc_now + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- 01: i_alu_ex.
- 10: i_pc_four_EX.
- 11: i_pred_pc.
- In every case, bits [1:0] of next_pc are forced to 00.

REQ-004 SHALL define redirect = i_flush & (i_pc_sel == 01 or i_pc_sel == 10).

REQ-005 SHALL update the PC register at each rising clock edge, in this priority order:
1. redirect: PC <= next_pc, regardless of i_stall or i_imem_ready.
2. Else, i_stall = 1: hold PC.
3. Else, i_imem_ready = 0: hold PC.
4. Else: PC <= next_pc.

REQ-006 SHALL drive o_imem_addr = o_pc_now combinationally, with zero latency.

REQ-007 SHALL update the IF/ID register at each rising clock edge, in this priority order:
1. i_flush = 1: o_valid_ID <= 0; o_instr_ID <= 0x0000_0013 (NOP); o_pred_taken_ID <= 0; o_pc_ID and o_pc_four_ID <= 0.
2. Else, i_stall = 1: hold all IF/ID fields.
3. Else, i_imem_ready = 0: insert a bubble, with the same values as the flush case.
4. Else: o_pc_ID <= o_pc_now; o_pc_four_ID <= o_pc_now + 4; o_instr_ID <= i_imem_rdata; o_valid_ID <= 1; o_pred_taken_ID <= (i_pc_sel == 11).

REQ-008 SHALL treat i_flush = 1 with i_pc_sel equal to 00 or 11 as a flush of IF/ID only; no PC redirect occurs, and the PC follows REQ-005 items 2-4.

REQ-009 SHALL count accepted flushes in o_flush_cnt:
- Increment by 1 on each rising edge with i_flush = 1.
- Saturate at 0xFFFF; never wrap.

REQ-010 SHALL give a new instruction a fetch-to-ID latency of one cycle: the word presented at edge N appears on the o_*_ID outputs after edge N.

REQ-011 SHALL keep every output glitch-free with respect to the registers:
- All o_*_ID outputs and o_flush_cnt are direct register outputs.
- o_pc_now is the PC register output.

Reset
REQ-012 SHALL, while i_rst_n = 0, asynchronously force:
- PC = 0x0000_0000.
- o_pc_ID = 0 and o_pc_four_ID = 0.
- o_instr_ID = 0x0000_0013.
- o_valid_ID = 0 and o_pred_taken_ID = 0.
- o_flush_cnt = 0.

REQ-013 SHALL, on the first rising edge after deassertion of i_rst_n with i_imem_ready = 1 and i_pc_sel = 00, load PC = 0x4 and capture the instruction at address 0x0 into IF/ID.

REQ-014 SHALL, when reset is asserted mid-stall or mid-flush, discard all pending state; no redirect or stall is remembered across reset.

Verification
REQ-015 Sequential fetch: reset, then i_imem_ready = 1 and i_pc_sel = 00 for 4 cycles -> o_pc_now = 0x10; o_pc_ID = 0xC; o_pc_four_ID = 0x10; o_valid_ID = 1.

REQ-016 Mispredict redirect: at PC = 0x20, apply i_flush = 1, i_pc_sel = 01, i_alu_ex = 0x100, and i_stall = 1 together -> next cycle o_pc_now = 0x100; o_valid_ID = 0; o_instr_ID = 0x13; o_flush_cnt increments.

REQ-017 Predicted taken: at PC = 0x40, apply i_pc_sel = 11 and i_pred_pc = 0x80 -> next cycle o_pc_now = 0x80; o_pc_ID = 0x40; o_pred_taken_ID = 1.

REQ-018 Stall and memory wait:
- i_stall = 1 for 3 cycles -> PC and all IF/ID fields are unchanged.
- Then i_imem_ready = 0 for 2 cycles -> PC is held and o_valid_ID = 0 (bubble).

REQ-019 Wrap-around: force PC = 0xFFFF_FFFC with i_pc_sel = 00 -> next o_pc_now = 0x0; o_pc_four_ID = 0x0.

REQ-020 Saturation and reset:
- 0x10005 consecutive flushes -> o_flush_cnt = 0xFFFF.
- Asserting i_rst_n = 0 mid-sequence -> all outputs take their REQ-012 reset values immediately, without waiting for a clock edge.
